fadd_pipe: RTL and testbench
============================

// Module: fadd_pipe
// PURPOSE
//  Pipelined, parametrised floating-point adder/subtractor for the systolic-array accumulate path.
//  Successor to the combinational single-format adder. Adds subtract mode, true effective subtraction
//  with leading-zero renormalisation, IEEE special-value handling and valid/ready backpressure.
//  Three register stages; full throughput of one operation per cycle; results leave in issue order.
// PARAMETERS
//  EXP_W   8              exponent width
//  M_W     7              stored mantissa width (8/7 = bfloat16, 8/23 = fp32)
//  TAG_W   4              width of the sideband tag carried with each operation
//  BIT_W   1+EXP_W+M_W    word width (localparam, not overridable)
// PORTS
//  clk        in   1      single clock; all state changes on its rising edge
//  rst_n      in   1      synchronous, active-low reset
//  in_valid   in   1      operands and mode are valid this cycle
//  in_ready   out  1      block accepts the operation when in_valid && in_ready
//  in_a       in   BIT_W  operand A, {sign, exp, mantissa}
//  in_b       in   BIT_W  operand B, same format as in_a
//  in_sub     in   1      0: A+B; 1: A-B (B sign inverted before alignment)
//  in_tag     in   TAG_W  opaque tag, returned unchanged with the result
//  out_valid  out  1      out_result, out_exc and out_tag are valid
//  out_ready  in   1      consumer accepts the result when out_valid && out_ready
//  out_result out  BIT_W  sum/difference
//  out_exc    out  3      {invalid, overflow, underflow}
//  out_tag    out  TAG_W  tag of the operation in out_result
// BEHAVIOUR
//  Reset (rst_n=0 at a clk edge):
//  - all stage valids and out_valid go to 0; out_result, out_exc and out_tag go to 0.
//  - in_ready=0 while rst_n=0. Operations in flight are discarded; none emerge after reset.
//  Pipeline (S1 align, S2 add, S3 normalise/pack; S3 register drives the out_* ports):
//  - Stage k loads when it is empty or its content moves on this cycle:
//    ready_k = !v_k | ready_(k+1); ready_4 = out_ready; in_ready = ready_1.
//  - A stalled stage holds its data. A beat is never dropped or duplicated.
//  - Latency is 3 cycles from the accept edge to out_valid when out_ready is held high.
//  S1: b' = in_b with sign ^= in_sub.
//  - Swap so A has the larger {exp,mantissa} magnitude (on a tie, keep A).
//  - Exponent 0 (denormal or zero) is treated as +/-0 (flush on input).
//  - Significands carry the hidden bit, then 2 guard bits: width M_W+3.
//  - d = expA-expB; B is shifted right by d; d >= M_W+3 gives 0 (no wrap of the shift amount).
//  S2: effective op = signA ^ signB'. Add or subtract aligned significands (M_W+4 bits, carry kept).
//  - Result sign = signA.
//  S3: on carry, shift right 1 and exponent +1.
//  - Otherwise count leading zeros L and shift left L with exponent -L.
//  - Truncate guard bits (round toward zero).
//  - Zero significand (exact cancellation): +0, no flag.
//  - Exponent <= 0 after normalisation: signed zero and underflow=1.
//  - Exponent >= 2^EXP_W-1: signed infinity and overflow=1.
//  Special values (take priority over S3 arithmetic):
//  - Any NaN input: canonical qNaN {0, all-ones exp, 1, zeros}, invalid=1.
//  - inf + (-inf) as effective subtract: canonical qNaN, invalid=1.
//  - inf op finite: that inf, with its sign after in_sub is applied; no flag.
//  - inf op inf of the same effective sign: that inf, no flag.
//  Simultaneous events:
//  - A new accept and an output handshake in the same cycle both take effect.
//  - A full pipe with out_ready=1 still accepts one operation per cycle.
// TESTING (bf16 defaults; hex words)
//  1) 3F80 + 4000, sub=0, tag=5, out_ready=1 -> 4040, exc=000, tag=5, exactly 3 cycles after accept.
//  2) 4040 - 3F80 -> 4000; 3F80 - 3F80 -> 0000; 3F80 + 3C00 -> 3F81; 3F80 + 3B80 -> 3F80 (truncated).
//  3) 7F7F + 7F7F -> 7F80 with overflow; 7F80 + FF80 -> 7FC0 with invalid; 7FC1 + 3F80 -> 7FC0 with invalid.
//  4) 6 back-to-back ops, out_ready=0 for 5 cycles -> in_ready drops once 3 are held;
//     all 6 results emerge in order with correct tags, none lost or duplicated.
//  5) 0080 - 0081 (cancels to below min normal) -> 8000 with underflow; 0001 + 3F80 (denormal flushed) -> 3F80.
//  6) rst_n=0 for one cycle while 3 ops are in flight -> out_valid=0 next cycle;
//     no stale result appears; the next op completes normally.

Source files
------------

// File: rtl/fadd_pipe.sv
// Three-stage pipelined floating-point adder/subtractor with valid/ready flow control.
// Stages: S1 decode/swap/align, S2 significand add/subtract, S3 normalise/pack (drives out_*).
module fadd_pipe #(
  parameter int unsigned EXP_W = 8,
  parameter int unsigned M_W   = 7,
  parameter int unsigned TAG_W = 4,
  localparam int unsigned BIT_W = 1 + EXP_W + M_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [BIT_W-1:0] in_a,
  input  logic [BIT_W-1:0] in_b,
  input  logic             in_sub,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [BIT_W-1:0] out_result,
  output logic [2:0]       out_exc,
  output logic [TAG_W-1:0] out_tag
);

  localparam int unsigned SIG_W  = M_W + 3;
  localparam int unsigned SUM_W  = M_W + 4;
  localparam int unsigned LZ_W   = $clog2(SIG_W + 1);
  localparam int unsigned EXP_SW = EXP_W + 2;
  localparam int          EXP_MAX = 2 ** EXP_W - 1;
  localparam logic [EXP_W-1:0] EXP_ONES = '1;
  localparam logic [BIT_W-1:0] QNAN = {1'b0, EXP_ONES, 1'b1, {(M_W - 1){1'b0}}};

  // Flow control: a stage loads when empty or when its content moves on
  logic v1, v2;
  logic ready1, ready2, ready3;

  assign ready3   = !out_valid || out_ready;
  assign ready2   = !v2 || ready3;
  assign ready1   = !v1 || ready2;
  assign in_ready = rst_n && ready1;

  // S1: decode, flush denormals, order by magnitude, align the smaller operand
  logic             a_sign, b_sign;
  logic [EXP_W-1:0] a_exp, b_exp, l_exp, s_exp, d;
  logic [M_W-1:0]   a_man, b_man, l_man, s_man;
  logic             a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
  logic             l_sign, s_sign, l_zero, s_zero, swap;
  logic [EXP_W+M_W-1:0] a_mag, b_mag;
  logic [SIG_W-1:0] l_sig, s_sig, s_al;
  logic             spc;
  logic [BIT_W-1:0] spc_res;
  logic [2:0]       spc_exc;

  assign a_sign = in_a[BIT_W-1];
  assign b_sign = in_b[BIT_W-1] ^ in_sub;
  assign a_exp  = in_a[BIT_W-2:M_W];
  assign b_exp  = in_b[BIT_W-2:M_W];
  assign a_man  = in_a[M_W-1:0];
  assign b_man  = in_b[M_W-1:0];

  always_comb begin
    a_nan  = (a_exp == EXP_ONES) && (a_man != '0);
    b_nan  = (b_exp == EXP_ONES) && (b_man != '0);
    a_inf  = (a_exp == EXP_ONES) && (a_man == '0);
    b_inf  = (b_exp == EXP_ONES) && (b_man == '0);
    a_zero = (a_exp == '0);
    b_zero = (b_exp == '0);
    a_mag  = a_zero ? '0 : in_a[BIT_W-2:0];
    b_mag  = b_zero ? '0 : in_b[BIT_W-2:0];
    swap   = b_mag > a_mag;
    l_sign = swap ? b_sign : a_sign;
    s_sign = swap ? a_sign : b_sign;
    l_exp  = swap ? b_exp  : a_exp;
    s_exp  = swap ? a_exp  : b_exp;
    l_man  = swap ? b_man  : a_man;
    s_man  = swap ? a_man  : b_man;
    l_zero = swap ? b_zero : a_zero;
    s_zero = swap ? a_zero : b_zero;
    l_sig  = l_zero ? '0 : {1'b1, l_man, 2'b00};
    s_sig  = s_zero ? '0 : {1'b1, s_man, 2'b00};
    d      = l_exp - s_exp;
    s_al   = (d >= EXP_W'(SIG_W)) ? '0 : (s_sig >> d);
    spc     = 1'b0;
    spc_res = '0;
    spc_exc = '0;
    if (a_nan || b_nan) begin
      spc = 1'b1; spc_res = QNAN; spc_exc = 3'b100;
    end else if (a_inf && b_inf) begin
      spc = 1'b1;
      if (a_sign != b_sign) begin
        spc_res = QNAN; spc_exc = 3'b100;
      end else begin
        spc_res = {a_sign, EXP_ONES, {M_W{1'b0}}};
      end
    end else if (a_inf) begin
      spc = 1'b1; spc_res = {a_sign, EXP_ONES, {M_W{1'b0}}};
    end else if (b_inf) begin
      spc = 1'b1; spc_res = {b_sign, EXP_ONES, {M_W{1'b0}}};
    end
  end

  logic             s1_sign, s1_sub, s1_spc;
  logic [EXP_W-1:0] s1_exp;
  logic [SIG_W-1:0] s1_sig_l, s1_sig_s;
  logic [BIT_W-1:0] s1_spc_res;
  logic [2:0]       s1_spc_exc;
  logic [TAG_W-1:0] s1_tag;

  // S2: magnitude add or subtract; larger operand first so no borrow out
  logic [SUM_W-1:0] sum;
  always_comb begin
    if (s1_sub) sum = {1'b0, s1_sig_l} - {1'b0, s1_sig_s};
    else        sum = {1'b0, s1_sig_l} + {1'b0, s1_sig_s};
  end

  logic             s2_sign, s2_spc;
  logic [EXP_W-1:0] s2_exp;
  logic [SUM_W-1:0] s2_sum;
  logic [BIT_W-1:0] s2_spc_res;
  logic [2:0]       s2_spc_exc;
  logic [TAG_W-1:0] s2_tag;

  // S3: renormalise, truncate guard bits, range-check the exponent
  logic [LZ_W-1:0]          lz;
  logic signed [EXP_SW-1:0] exp_n;
  logic [M_W-1:0]           man;
  logic [BIT_W-1:0]         res;
  logic [2:0]               exc;

  always_comb begin
    lz = '0;
    for (int i = 0; i < SIG_W; i++) begin
      if (s2_sum[i]) lz = LZ_W'(SIG_W - 1 - i);
    end
    if (s2_sum[SUM_W-1]) begin
      man   = M_W'(s2_sum >> 3);
      exp_n = EXP_SW'(s2_exp) + EXP_SW'(1);
    end else begin
      man   = M_W'((s2_sum[SIG_W-1:0] << lz) >> 2);
      exp_n = EXP_SW'(s2_exp) - EXP_SW'(lz);
    end
    res = '0;
    exc = '0;
    if (s2_spc) begin
      res = s2_spc_res;
      exc = s2_spc_exc;
    end else if (s2_sum == '0) begin
      res = '0;
    end else if (exp_n <= EXP_SW'(0)) begin
      res = {s2_sign, {(BIT_W - 1){1'b0}}};
      exc = 3'b001;
    end else if (exp_n >= EXP_SW'(EXP_MAX)) begin
      res = {s2_sign, EXP_ONES, {M_W{1'b0}}};
      exc = 3'b010;
    end else begin
      res = {s2_sign, exp_n[EXP_W-1:0], man};
    end
  end

  // Pipeline registers; data only moves with a valid beat
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v1         <= 1'b0;
      v2         <= 1'b0;
      out_valid  <= 1'b0;
      out_result <= '0;
      out_exc    <= '0;
      out_tag    <= '0;
    end else begin
      if (ready1) begin
        v1 <= in_valid;
        if (in_valid) begin
          s1_sign    <= l_sign;
          s1_sub     <= l_sign ^ s_sign;
          s1_exp     <= l_exp;
          s1_sig_l   <= l_sig;
          s1_sig_s   <= s_al;
          s1_spc     <= spc;
          s1_spc_res <= spc_res;
          s1_spc_exc <= spc_exc;
          s1_tag     <= in_tag;
        end
      end
      if (ready2) begin
        v2 <= v1;
        if (v1) begin
          s2_sign    <= s1_sign;
          s2_exp     <= s1_exp;
          s2_sum     <= sum;
          s2_spc     <= s1_spc;
          s2_spc_res <= s1_spc_res;
          s2_spc_exc <= s1_spc_exc;
          s2_tag     <= s1_tag;
        end
      end
      if (ready3) begin
        out_valid <= v2;
        if (v2) begin
          out_result <= res;
          out_exc    <= exc;
          out_tag    <= s2_tag;
        end
      end
    end
  end

endmodule

// File: tb/tb_fadd_pipe.sv
// Randomised bench for fadd_pipe (bf16 defaults) with an arithmetic reference model and
// an in-order scoreboard, plus directed cases for latency, backpressure and reset.
module tb_fadd_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, in_sub;
  logic [15:0] in_a, in_b;
  logic [3:0]  in_tag;
  logic        out_valid, out_ready;
  logic [15:0] out_result;
  logic [2:0]  out_exc;
  logic [3:0]  out_tag;

  fadd_pipe dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_sub(in_sub), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_exc(out_exc), .out_tag(out_tag)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int n_out = 0;
  logic acc, last_ov, last_ir;
  logic [22:0] last_pop;
  logic [22:0] q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  // Reference: exact integer arithmetic on scaled significands, spec rules applied directly
  function automatic logic [18:0] model(input logic [15:0] a, input logic [15:0] b, input logic sub);
    int ea, eb, ma, mb, mag_a, mag_b, el, es, sl, ss, d, r, e;
    logic sa, sb, sgn;
    ea = int'(a[14:7]); ma = int'(a[6:0]); sa = a[15];
    eb = int'(b[14:7]); mb = int'(b[6:0]); sb = b[15] ^ sub;
    if ((ea == 255 && ma != 0) || (eb == 255 && mb != 0)) return {3'b100, 16'h7FC0};
    if (ea == 255 && eb == 255) return (sa != sb) ? {3'b100, 16'h7FC0} : {3'b000, sa, 15'h7F80};
    if (ea == 255) return {3'b000, sa, 15'h7F80};
    if (eb == 255) return {3'b000, sb, 15'h7F80};
    mag_a = (ea == 0) ? 0 : int'(a[14:0]);
    mag_b = (eb == 0) ? 0 : int'(b[14:0]);
    sl = (ea == 0) ? 0 : (128 + ma) * 4;
    ss = (eb == 0) ? 0 : (128 + mb) * 4;
    el = ea; es = eb; sgn = sa;
    if (mag_b > mag_a) begin
      el = eb; es = ea; sgn = sb;
      r = sl; sl = ss; ss = r;
    end
    d = el - es;
    ss = (d >= 10) ? 0 : (ss >> d);
    r = (sa != sb) ? sl - ss : sl + ss;
    e = el;
    if (r == 0) return 19'h0;
    while (r >= 1024) begin r = r / 2; e++; end
    while (r < 512) begin r = r * 2; e--; end
    if (e <= 0) return {3'b001, sgn, 15'h0};
    if (e >= 255) return {3'b010, sgn, 15'h7F80};
    return {3'b000, sgn, 8'(e), 7'((r / 4) % 128)};
  endfunction

  // One clock: drive after the falling edge, then sample and score both handshakes
  task automatic step(input logic v, input logic [15:0] a, input logic [15:0] b, input logic s,
                      input logic [3:0] t, input logic ordy, input logic rst);
    logic [22:0] e;
    @(negedge clk);
    in_valid = v; in_a = a; in_b = b; in_sub = s; in_tag = t; out_ready = ordy; rst_n = rst;
    #1;
    acc = 1'b0;
    if (!rst) begin
      q.delete();
    end else begin
      if (out_valid && out_ready) begin
        n_out++;
        last_pop = {out_tag, out_exc, out_result};
        if (q.size() == 0) begin
          chk("spurious_out", {9'h0, out_tag, out_exc, out_result}, 32'hFFFF_FFFF);
        end else begin
          e = q.pop_front();
          chk("result", {9'h0, out_tag, out_exc, out_result}, {9'h0, e});
        end
      end
      if (in_valid && in_ready) begin
        acc = 1'b1;
        q.push_back({in_tag, model(in_a, in_b, in_sub)});
      end
    end
    last_ov = out_valid;
    last_ir = in_ready;
  endtask

  task automatic drain();
    for (int c = 0; c < 50 && q.size() > 0; c++) step(1'b0, 16'h0, 16'h0, 1'b0, 4'h0, 1'b1, 1'b1);
    chk("drain_empty", q.size(), 0);
  endtask

  function automatic logic [15:0] rnd_op(input logic [15:0] ref_w);
    int sel;
    logic [15:0] w;
    sel = $urandom_range(0, 9);
    w = 16'($urandom);
    if (sel == 0) begin
      case ($urandom_range(0, 7))
        0: w = 16'h7F80;
        1: w = 16'hFF80;
        2: w = 16'h7FC0;
        3: w = 16'h7F81;
        4: w = 16'h0000;
        5: w = 16'h8000;
        6: w = 16'h0003;
        default: w = 16'h7F7F;
      endcase
    end else if (sel <= 5) begin
      w[14:7] = ref_w[14:7] + 8'($urandom_range(0, 3));
    end
    return w;
  endfunction

  logic [15:0] t4_a[6];
  logic [15:0] t4_b[6];
  logic [15:0] ra, rb;
  int idx, lat, out0;

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_sub = 1'b0; in_tag = '0; out_ready = 1'b0;

    // Pin the model with hand-computed values
    chk("pin_add",     {13'h0, model(16'h3F80, 16'h4000, 1'b0)}, {13'h0, 3'b000, 16'h4040});
    chk("pin_sub",     {13'h0, model(16'h4040, 16'h3F80, 1'b1)}, {13'h0, 3'b000, 16'h4000});
    chk("pin_cancel",  {13'h0, model(16'h3F80, 16'h3F80, 1'b1)}, {13'h0, 3'b000, 16'h0000});
    chk("pin_lsb",     {13'h0, model(16'h3F80, 16'h3C00, 1'b0)}, {13'h0, 3'b000, 16'h3F81});
    chk("pin_trunc",   {13'h0, model(16'h3F80, 16'h3B80, 1'b0)}, {13'h0, 3'b000, 16'h3F80});
    chk("pin_ovf",     {13'h0, model(16'h7F7F, 16'h7F7F, 1'b0)}, {13'h0, 3'b010, 16'h7F80});
    chk("pin_infinf",  {13'h0, model(16'h7F80, 16'hFF80, 1'b0)}, {13'h0, 3'b100, 16'h7FC0});
    chk("pin_nan",     {13'h0, model(16'h7FC1, 16'h3F80, 1'b0)}, {13'h0, 3'b100, 16'h7FC0});
    chk("pin_uflow",   {13'h0, model(16'h0080, 16'h0081, 1'b1)}, {13'h0, 3'b001, 16'h8000});
    chk("pin_flush",   {13'h0, model(16'h0001, 16'h3F80, 1'b0)}, {13'h0, 3'b000, 16'h3F80});

    // Reset state
    for (int i = 0; i < 3; i++) step(1'b1, 16'h3F80, 16'h3F80, 1'b0, 4'h1, 1'b1, 1'b0);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_in_ready",  32'(in_ready), 0);
    chk("rst_outputs",   {9'h0, out_tag, out_exc, out_result}, 0);

    // Test 1: basic add and latency
    step(1'b1, 16'h3F80, 16'h4000, 1'b0, 4'h5, 1'b1, 1'b1);
    chk("t1_accept", 32'(acc), 1);
    lat = 99;
    for (int c = 1; c <= 8 && lat == 99; c++) begin
      step(1'b0, 16'h0, 16'h0, 1'b0, 4'h0, 1'b1, 1'b1);
      if (last_ov) lat = c;
    end
    chk("t1_latency", lat, 3);
    chk("t1_result", {9'h0, last_pop}, {9'h0, 4'h5, 3'b000, 16'h4040});

    // Tests 2, 3, 5 streamed back-to-back through the scoreboard
    step(1'b1, 16'h4040, 16'h3F80, 1'b1, 4'h2, 1'b1, 1'b1);
    step(1'b1, 16'h3F80, 16'h3F80, 1'b1, 4'h3, 1'b1, 1'b1);
    step(1'b1, 16'h3F80, 16'h3C00, 1'b0, 4'h4, 1'b1, 1'b1);
    step(1'b1, 16'h3F80, 16'h3B80, 1'b0, 4'h5, 1'b1, 1'b1);
    step(1'b1, 16'h7F7F, 16'h7F7F, 1'b0, 4'h6, 1'b1, 1'b1);
    step(1'b1, 16'h7F80, 16'hFF80, 1'b0, 4'h7, 1'b1, 1'b1);
    step(1'b1, 16'h7FC1, 16'h3F80, 1'b0, 4'h8, 1'b1, 1'b1);
    step(1'b1, 16'h0080, 16'h0081, 1'b1, 4'h9, 1'b1, 1'b1);
    step(1'b1, 16'h0001, 16'h3F80, 1'b0, 4'hA, 1'b1, 1'b1);
    step(1'b1, 16'h7F80, 16'h3F80, 1'b1, 4'hB, 1'b1, 1'b1);
    step(1'b1, 16'h3F80, 16'h7F80, 1'b1, 4'hC, 1'b1, 1'b1);
    drain();

    // Full throughput with the consumer always ready
    idx = 0;
    for (int c = 0; c < 8; c++) begin
      step(1'b1, rnd_op(16'h3F80), rnd_op(16'h3F80), 1'($urandom), 4'(c), 1'b1, 1'b1);
      if (acc) idx++;
    end
    chk("thru_accepts", idx, 8);
    drain();

    // Test 4: six ops against a consumer stalled for five cycles
    for (int i = 0; i < 6; i++) begin
      t4_a[i] = rnd_op(16'h4000);
      t4_b[i] = rnd_op(t4_a[i]);
    end
    idx = 0;
    out0 = n_out;
    for (int c = 0; c < 40 && (idx < 6 || q.size() > 0); c++) begin
      step(idx < 6, (idx < 6) ? t4_a[idx] : 16'h0, (idx < 6) ? t4_b[idx] : 16'h0, 1'(idx),
           4'(idx + 1), c >= 5, 1'b1);
      if (acc) idx++;
      if (c == 4) begin
        chk("t4_held", idx, 3);
        chk("t4_in_ready", 32'(last_ir), 0);
      end
    end
    chk("t4_count", n_out - out0, 6);

    // Test 6: reset with three ops in flight
    for (int i = 0; i < 3; i++) step(1'b1, 16'h3F80, 16'h4000, 1'b0, 4'(i), 1'b1, 1'b1);
    step(1'b0, 16'h0, 16'h0, 1'b0, 4'h0, 1'b1, 1'b0);
    step(1'b0, 16'h0, 16'h0, 1'b0, 4'h0, 1'b1, 1'b1);
    chk("t6_out_valid", 32'(last_ov), 0);
    out0 = n_out;
    for (int i = 0; i < 4; i++) step(1'b0, 16'h0, 16'h0, 1'b0, 4'h0, 1'b1, 1'b1);
    chk("t6_no_stale", n_out - out0, 0);
    step(1'b1, 16'h4040, 16'h3F80, 1'b0, 4'hE, 1'b1, 1'b1);
    drain();
    chk("t6_next_op", n_out - out0, 1);
    chk("t6_next_val", {9'h0, last_pop}, {9'h0, 4'hE, 3'b000, 16'h4080});

    // Randomised traffic with random backpressure
    for (int c = 0; c < 3000; c++) begin
      ra = rnd_op(16'($urandom));
      rb = rnd_op(ra);
      step($urandom_range(0, 3) != 0, ra, rb, 1'($urandom), 4'($urandom),
           $urandom_range(0, 9) < 7, 1'b1);
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
